// File: rtl/eth_pkg.sv
// -----------------------------------------------------------------------------
// eth_pkg
// Shared constants for the RMII MAC receive and transmit paths: dibit codes
// seen on the RMII data pins, preamble/SFD byte values, legal frame-length
// limits (DA through FCS inclusive), and the receive FSM state encodings.
// -----------------------------------------------------------------------------
package eth_pkg;

    localparam logic [1:0] DIBIT_PRE = 2'b01;
    localparam logic [1:0] DIBIT_SFD = 2'b11;

    localparam logic [7:0] PRE_BYTE  = 8'h55;
    localparam logic [7:0] SFD_BYTE  = 8'hD5;

    localparam int ETH_MIN_FRAME = 64;
    localparam int ETH_MAX_FRAME = 1518;
    localparam int ETH_MIN_PRE   = 4;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PREAMBLE = 3'd1;
    localparam logic [2:0] BODY     = 3'd2;
    localparam logic [2:0] EOF      = 3'd3;
    localparam logic [2:0] DROP     = 3'd4;

endpackage

// File: rtl/eth_rx_if.sv
// -----------------------------------------------------------------------------
// eth_rx_if
// Receive beat stream shared with the packet-processing logic (same format the
// transmit path consumes). No backpressure.
//   rx_vld : beat strobe, one cycle wide
//   rx_dat : payload byte, valid when rx_vld=1 and rx_eof=0
//   rx_sof : first payload byte of a frame
//   rx_eof : end-of-frame beat, carries no data (rx_dat=0)
//   rx_err : frame bad, qualified by rx_vld & rx_eof
// master drives the stream (eth_rx), slave consumes it.
// -----------------------------------------------------------------------------
interface eth_rx_if;

    logic       rx_vld;
    logic [7:0] rx_dat;
    logic       rx_sof;
    logic       rx_eof;
    logic       rx_err;

    modport master (output rx_vld, rx_dat, rx_sof, rx_eof, rx_err);
    modport slave  (input  rx_vld, rx_dat, rx_sof, rx_eof, rx_err);

endinterface

// File: rtl/crc32.sv
// -----------------------------------------------------------------------------
// crc32
// Byte-wide Ethernet CRC-32 (reflected polynomial 0xEDB88320, init all-ones).
// The output is the FCS arranged in wire order: crc[31:24] is the first FCS
// byte on the wire, crc[7:0] the last.
//   clk  : clock
//   rst  : synchronous, active-high; restarts the accumulation
//   vld  : consume data this cycle
//   data : byte to accumulate
//   crc  : FCS of all bytes consumed since rst
// -----------------------------------------------------------------------------
module crc32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        vld,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] state_q;

    function automatic logic [31:0] crc_step(input logic [31:0] s, input logic [7:0] d);
        logic [31:0] r;
        r = s ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= 32'hFFFF_FFFF;
        end else if (vld) begin
            state_q <= crc_step(state_q, data);
        end
    end

    // The reflected register's low byte goes out first, complemented.
    assign crc = ~{state_q[7:0], state_q[15:8], state_q[23:16], state_q[31:24]};

endmodule

// File: rtl/eth_rx.sv
// -----------------------------------------------------------------------------
// eth_rx
// RMII receive MAC. Deserialises 2-bit dibits (LSB dibit first) at clk_mac,
// strips preamble/SFD, holds back the trailing 4 bytes as FCS, checks the FCS
// and length, and presents payload bytes as sof/data/eof beats.
//   clk_mac   : 50 MHz RMII reference clock
//   rst_n     : synchronous, active-low reset
//   eth_crsdv : RMII CRS_DV
//   eth_rxd   : RMII RXD dibit
//   eth_rxerr : PHY receive error
//   rx        : beat stream (eth_rx_if master)
// -----------------------------------------------------------------------------
module eth_rx
    import eth_pkg::*;
#(
    parameter int MIN_FRAME = ETH_MIN_FRAME,
    parameter int MAX_FRAME = ETH_MAX_FRAME,
    parameter int MIN_PRE   = ETH_MIN_PRE
) (
    input  logic       clk_mac,
    input  logic       rst_n,
    input  logic       eth_crsdv,
    input  logic [1:0] eth_rxd,
    input  logic       eth_rxerr,
    eth_rx_if.master   rx
);

    localparam logic [3:0]  MIN_PRE_C   = 4'(MIN_PRE);
    localparam logic [10:0] MIN_FRAME_C = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_FRAME_C = 11'(MAX_FRAME);

    logic       crs_p0, rxerr_p0;
    logic [1:0] rxd_p0;
    logic       crs_p1, rxerr_p1;
    logic [1:0] rxd_p1;

    logic [2:0]  state;
    logic        post_rst;
    logic [3:0]  pre_cnt;
    logic [1:0]  dibit_idx;
    logic [5:0]  shift_reg;
    logic [7:0]  dl [4];
    logic [2:0]  dl_cnt;
    logic [10:0] byte_cnt;
    logic        first_beat;
    logic        rxerr_seen;

    logic       vld_q, sof_q, eof_q, err_q;
    logic [7:0] dat_q;

    logic        end_seen;
    logic        byte_done;
    logic        dl_full;
    logic        overlen;
    logic        crc_vld;
    logic        crc_rst;
    logic        fcs_ok;
    logic [7:0]  new_byte;
    logic [31:0] crc_code;

    // ---- stage p0: pad registers (IOB flops) ----
    // ---- stage p1: one dibit of lookahead ----
    // The FSM consumes the p1 dibit while peeking at p0's CRS_DV, so the first
    // low cycle of end-of-carrier is recognised as non-data, while a single low
    // cycle (CRS toggling) followed by high is still data.
    always_ff @(posedge clk_mac) begin
        crs_p0   <= eth_crsdv;
        rxd_p0   <= eth_rxd;
        rxerr_p0 <= eth_rxerr;
        crs_p1   <= crs_p0;
        rxd_p1   <= rxd_p0;
        rxerr_p1 <= rxerr_p0;
    end

    assign end_seen  = !crs_p1 && !crs_p0;
    assign byte_done = (state == BODY) && !end_seen && (dibit_idx == 2'd3);
    assign new_byte  = {rxd_p1, shift_reg};
    assign dl_full   = (dl_cnt == 3'd4);
    assign overlen   = (byte_cnt == MAX_FRAME_C);
    // Only bytes leaving the delay line reach the CRC; the held-back 4 are FCS.
    assign crc_vld   = byte_done && dl_full && !overlen;
    assign crc_rst   = !rst_n || (state == IDLE);
    assign fcs_ok    = ({dl[0], dl[1], dl[2], dl[3]} == crc_code);

    crc32 u_crc32 (
        .clk  (clk_mac),
        .rst  (crc_rst),
        .vld  (crc_vld),
        .data (dl[0]),
        .crc  (crc_code)
    );

    // ---- stage p2: FSM and registered beat outputs ----
    always_ff @(posedge clk_mac) begin
        if (!rst_n) begin
            state    <= IDLE;
            post_rst <= 1'b1;
            vld_q    <= 1'b0;
            dat_q    <= 8'd0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            post_rst <= 1'b0;
            vld_q    <= 1'b0;
            dat_q    <= 8'd0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            err_q    <= 1'b0;

            case (state)
                IDLE: begin
                    pre_cnt <= 4'd0;
                    // Carrier already up as reset releases: we are mid-frame.
                    if (crs_p0) begin
                        state <= post_rst ? DROP : PREAMBLE;
                    end
                end

                PREAMBLE: begin
                    if (end_seen) begin
                        state <= IDLE;
                    end else if (rxd_p1 == 2'b00) begin
                        state <= PREAMBLE;
                    end else if (rxd_p1 == DIBIT_PRE) begin
                        if (pre_cnt != 4'hF) begin
                            pre_cnt <= pre_cnt + 4'd1;
                        end
                    end else if (rxd_p1 == DIBIT_SFD && pre_cnt >= MIN_PRE_C) begin
                        state      <= BODY;
                        dibit_idx  <= 2'd0;
                        byte_cnt   <= 11'd0;
                        dl_cnt     <= 3'd0;
                        first_beat <= 1'b1;
                        rxerr_seen <= 1'b0;
                    end else begin
                        state <= DROP;
                    end
                end

                BODY: begin
                    if (rxerr_p1) begin
                        rxerr_seen <= 1'b1;
                    end
                    if (end_seen) begin
                        state <= EOF;
                    end else begin
                        shift_reg <= {rxd_p1, shift_reg[5:2]};
                        dibit_idx <= dibit_idx + 2'd1;
                        if (dibit_idx == 2'd3) begin
                            dl[0] <= dl[1];
                            dl[1] <= dl[2];
                            dl[2] <= dl[3];
                            dl[3] <= new_byte;
                            if (byte_cnt != 11'h7FF) begin
                                byte_cnt <= byte_cnt + 11'd1;
                            end
                            if (!dl_full) begin
                                dl_cnt <= dl_cnt + 3'd1;
                            end
                            if (overlen) begin
                                // This push would be byte MAX_FRAME+1: close now.
                                vld_q <= 1'b1;
                                eof_q <= 1'b1;
                                err_q <= 1'b1;
                                state <= DROP;
                            end else if (dl_full) begin
                                vld_q      <= 1'b1;
                                dat_q      <= dl[0];
                                sof_q      <= first_beat;
                                first_beat <= 1'b0;
                            end
                        end
                    end
                end

                EOF: begin
                    vld_q <= 1'b1;
                    eof_q <= 1'b1;
                    err_q <= (dibit_idx != 2'd0) || (byte_cnt < MIN_FRAME_C) ||
                             (byte_cnt > MAX_FRAME_C) || rxerr_seen || !dl_full || !fcs_ok;
                    state <= IDLE;
                end

                DROP: begin
                    if (end_seen) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign rx.rx_vld = vld_q;
    assign rx.rx_dat = dat_q;
    assign rx.rx_sof = sof_q;
    assign rx.rx_eof = eof_q;
    assign rx.rx_err = err_q;

endmodule

// File: tb/tb_eth_rx.sv
// -----------------------------------------------------------------------------
// tb_eth_rx
// Directed frame vectors for eth_rx. Each table row describes a frame to put on
// the RMII pins and the beats expected back; a monitor records every beat and a
// checker compares the record to the row. A few hand-written sequences cover
// reset behaviour.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_eth_rx;
    import eth_pkg::*;

    logic       clk_mac   = 1'b0;
    logic       rst_n     = 1'b0;
    logic       eth_crsdv = 1'b0;
    logic [1:0] eth_rxd   = 2'b00;
    logic       eth_rxerr = 1'b0;

    eth_rx_if rx_bus ();

    eth_rx dut (
        .clk_mac   (clk_mac),
        .rst_n     (rst_n),
        .eth_crsdv (eth_crsdv),
        .eth_rxd   (eth_rxd),
        .eth_rxerr (eth_rxerr),
        .rx        (rx_bus)
    );

    always #10 clk_mac = ~clk_mac;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk_mac) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] dat;
        logic       sof;
        logic       eof;
        logic       err;
        int         cyc;
    } beat_t;

    // len/seed: payload bytes (seed+i); pad: pad payload to 60 with zeros;
    // pre01: 01-dibits before the SFD dibit; bad_fcs: flip bit0 of last FCS byte;
    // no_fcs: omit FCS; err_dibit: body dibit index with eth_rxerr high (-1 none);
    // tail: extra dibits after the last byte; toggle: CRS_DV toggles on last 8.
    typedef struct {
        int len;
        int seed;
        int pad;
        int pre01;
        int bad_fcs;
        int no_fcs;
        int err_dibit;
        int tail;
        int toggle;
        int exp_beats;
        int exp_eof;
        int exp_err;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    beat_t      beats [$];
    logic [7:0] exp_pl [$];

    always @(negedge clk_mac) begin
        if (rst_n && rx_bus.rx_vld) begin
            beats.push_back('{rx_bus.rx_dat, rx_bus.rx_sof, rx_bus.rx_eof, rx_bus.rx_err, cyc});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int id, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL vec%0d %s: got %0d want %0d", id, nm, act, exp);
        end
    endtask

    function automatic logic [31:0] fcs_of(input logic [7:0] b [$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic drive(input logic crs, input logic [1:0] d, input logic er);
        @(negedge clk_mac);
        eth_crsdv = crs;
        eth_rxd   = d;
        eth_rxerr = er;
    endtask

    task automatic send_vec(input vec_t v);
        logic [7:0]  fr [$];
        logic [1:0]  dq [$];
        logic [31:0] fcs;
        logic [7:0]  b;
        logic        crs;
        int          n;
        exp_pl.delete();
        n = v.len;
        if (v.pad != 0 && n < 60) n = 60;
        for (int i = 0; i < n; i++) begin
            b = (i < v.len) ? 8'(i + v.seed) : 8'h00;
            fr.push_back(b);
            exp_pl.push_back(b);
        end
        if (v.no_fcs == 0) begin
            fcs = fcs_of(fr);
            for (int k = 0; k < 4; k++) fr.push_back(fcs[8*k +: 8]);
            if (v.bad_fcs != 0) fr[fr.size()-1] = fr[fr.size()-1] ^ 8'h01;
        end
        foreach (fr[i]) begin
            for (int k = 0; k < 4; k++) dq.push_back(fr[i][2*k +: 2]);
        end
        for (int k = 0; k < v.tail; k++) dq.push_back(2'b10);
        drive(1'b1, 2'b00, 1'b0);
        for (int k = 0; k < v.pre01; k++) drive(1'b1, DIBIT_PRE, 1'b0);
        drive(1'b1, DIBIT_SFD, 1'b0);
        foreach (dq[i]) begin
            crs = 1'b1;
            if (v.toggle != 0 && i >= dq.size() - 8 && ((dq.size() - 1 - i) % 2) == 1) crs = 1'b0;
            drive(crs, dq[i], (i == v.err_dibit));
        end
        repeat (20) drive(1'b0, 2'b00, 1'b0);
    endtask

    task automatic check_vec(input int id, input vec_t v);
        int   nd        = 0;
        int   ne        = 0;
        int   first_bad = -1;
        int   sof_bad   = 0;
        int   eof_err   = 0;
        int   eof_last  = 1;
        int   gap_bad   = 0;
        int   eofdat    = 0;
        foreach (beats[i]) begin
            if (beats[i].eof) begin
                ne++;
                eof_err = int'(beats[i].err);
                if (i != beats.size() - 1) eof_last = 0;
                if (beats[i].dat != 8'd0 || beats[i].sof) eofdat++;
                if (i > 0 && beats[i].cyc - beats[i-1].cyc < 2) gap_bad++;
            end else begin
                if (first_bad < 0 && (nd >= exp_pl.size() || beats[i].dat != exp_pl[nd])) first_bad = nd;
                if (beats[i].sof != (nd == 0)) sof_bad++;
                if (i > 0 && beats[i].cyc - beats[i-1].cyc < 4) gap_bad++;
                nd++;
            end
        end
        check("data_beats", id, nd, v.exp_beats);
        check("first_bad_byte_idx", id, first_bad, -1);
        check("sof_misplaced", id, sof_bad, 0);
        check("eof_beats", id, ne, v.exp_eof);
        check("eof_not_last", id, eof_last, 1);
        check("beat_spacing", id, gap_bad, 0);
        check("eof_dat_sof", id, eofdat, 0);
        if (ne == 1) check("eof_err", id, eof_err, v.exp_err);
        beats.delete();
    endtask

    task automatic check_idle_outputs(input int id);
        check("out_vld", id, int'(rx_bus.rx_vld), 0);
        check("out_dat", id, int'(rx_bus.rx_dat), 0);
        check("out_sof", id, int'(rx_bus.rx_sof), 0);
        check("out_eof", id, int'(rx_bus.rx_eof), 0);
        check("out_err", id, int'(rx_bus.rx_err), 0);
    endtask

    initial begin
        //           len  seed pad pre bfcs nfcs errd tail tog  beats eof err
        vecs[0]  = '{60,    0, 0, 31, 0,   0,   -1,  0,   0,   60,   1,  0};  // good 64B
        vecs[1]  = '{60,    0, 0, 31, 1,   0,   -1,  0,   0,   60,   1,  1};  // bad FCS
        vecs[2]  = '{16,    0, 0, 31, 0,   0,   -1,  0,   0,   16,   1,  1};  // 20B runt
        vecs[3]  = '{60,    5, 0, 31, 0,   0,  100,  0,   0,   60,   1,  1};  // rxerr pulse
        vecs[4]  = '{60,    9, 0, 31, 0,   0,   -1,  1,   0,   60,   1,  1};  // misaligned
        vecs[5]  = '{60,   17, 0, 31, 0,   0,   -1,  0,   1,   60,   1,  0};  // CRS toggling
        vecs[6]  = '{100,  33, 1, 31, 0,   0,   -1,  0,   0,  100,   1,  0};  // loopback 100B
        vecs[7]  = '{10,   77, 1, 31, 0,   0,   -1,  0,   0,   60,   1,  0};  // loopback 10B padded
        vecs[8]  = '{59,    0, 0, 31, 0,   0,   -1,  0,   0,   59,   1,  1};  // 63B, one short
        vecs[9]  = '{1514,  3, 0, 31, 0,   0,   -1,  0,   0, 1514,   1,  0};  // exactly 1518B
        vecs[10] = '{1515,  3, 0, 31, 0,   0,   -1,  0,   0, 1514,   1,  1};  // 1519B overlength
        vecs[11] = '{2,     0, 0, 31, 0,   1,   -1,  0,   0,    0,   1,  1};  // under 4 bytes
        vecs[12] = '{60,    0, 0,  3, 0,   0,   -1,  0,   0,    0,   0,  0};  // preamble too short
        vecs[13] = '{60,   64, 0,  4, 0,   0,   -1,  0,   0,   60,   1,  0};  // minimum preamble

        rst_n = 1'b0;
        repeat (5) drive(1'b0, 2'b00, 1'b0);
        check_idle_outputs(-1);
        rst_n = 1'b1;
        repeat (5) drive(1'b0, 2'b00, 1'b0);
        check_idle_outputs(-2);

        for (int i = 0; i < NVEC; i++) begin
            send_vec(vecs[i]);
            check_vec(i, vecs[i]);
        end

        // Reset pulse in the middle of a frame body; the remainder of that
        // frame must be ignored once reset lifts with carrier still up.
        fork
            send_vec(vecs[0]);
            begin
                repeat (80) @(negedge clk_mac);
                #2 rst_n = 1'b0;
                repeat (3) @(negedge clk_mac);
                check_idle_outputs(100);
                rst_n = 1'b1;
                beats.delete();
            end
        join
        check("beats_after_reset", 100, beats.size(), 0);
        beats.delete();

        send_vec(vecs[0]);
        check_vec(101, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
